// File: rtl/bcd2_counter.sv
// bcd2_counter: two-digit packed-BCD up-counter (00..TERMINAL) with a
// level-sensitive count enable.
//
// Ports:
//   clk       - system clock, all state changes on the rising edge
//   reset     - synchronous, active-high clear (priority over x)
//   x         - count enable, sampled on every rising clk edge
//   bcd2_out  - registered count, [7:4] tens digit, [3:0] ones digit
//
// Parameter:
//   TERMINAL  - last value before wrap, decimal 1..99 (default 99)
//
// Build option:
//   BCD2_SATURATE_EN - when defined, the counter holds at TERMINAL instead
//                      of wrapping to 00; only reset leaves that state.

module bcd2_counter #(
    parameter int TERMINAL = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       x,
    output logic [7:0] bcd2_out
);

    if (TERMINAL < 1 || TERMINAL > 99) begin : g_bad_terminal
        $error("bcd2_counter: TERMINAL=%0d outside legal range 1..99", TERMINAL);
    end

    localparam logic [3:0] TERM_TENS = 4'(TERMINAL / 10);
    localparam logic [3:0] TERM_ONES = 4'(TERMINAL % 10);

    logic [3:0] ones_q, ones_d;
    logic [3:0] tens_q, tens_d;
    logic       ones_carry;
    logic       at_terminal;
    logic       invalid_bcd;

    assign ones_carry  = x && (ones_q == 4'd9);
    assign at_terminal = (tens_q == TERM_TENS) && (ones_q == TERM_ONES);
    // Any nibble above 9 can only come from X-recovery or upset; the next
    // enabled increment forces the counter back to 00.
    assign invalid_bcd = (ones_q > 4'd9) || (tens_q > 4'd9);

    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        if (x) begin
            if (invalid_bcd) begin
                ones_d = 4'd0;
                tens_d = 4'd0;
            end else if (at_terminal) begin
`ifdef BCD2_SATURATE_EN
                ones_d = ones_q;
                tens_d = tens_q;
`else
                ones_d = 4'd0;
                tens_d = 4'd0;
`endif
            end else if (ones_carry) begin
                ones_d = 4'd0;
                // tens==9 here means the count sits above TERMINAL; roll to 0
                // rather than producing an invalid nibble.
                tens_d = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ones_q <= 4'd0;
            tens_q <= 4'd0;
        end else begin
            ones_q <= ones_d;
            tens_q <= tens_d;
        end
    end

    assign bcd2_out = {tens_q, ones_q};

endmodule

// File: tb/tb_bcd2_counter.sv
module tb_bcd2_counter;

    logic       clk;
    logic       reset;
    logic       x;
    logic [7:0] out99;
    logic [7:0] out59;

    int n_checks = 0;
    int n_fail   = 0;

    bcd2_counter #(.TERMINAL(99)) dut99 (.clk(clk), .reset(reset), .x(x), .bcd2_out(out99));
    bcd2_counter #(.TERMINAL(59)) dut59 (.clk(clk), .reset(reset), .x(x), .bcd2_out(out59));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model: plain decimal integers ----------------
`ifdef BCD2_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    function automatic int next_val(int v, int term);
        if (v == term) return SAT ? term : 0;
        return (v + 1) % 100;
    endfunction

    function automatic logic [7:0] to_bcd(int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    int m99 = 0;
    int m59 = 0;
    bit m_valid = 1'b0;
    bit chk_en  = 1'b1;

    always @(posedge clk) begin
        if (reset) begin
            m99 = 0;
            m59 = 0;
            m_valid = 1'b1;
        end else if (m_valid && x) begin
            m99 = next_val(m99, 99);
            m59 = next_val(m59, 59);
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bcd(input string name, input logic [7:0] act);
        n_checks++;
        if ($isunknown(act) || act[7:4] > 4'd9 || act[3:0] > 4'd9) begin
            n_fail++;
            $display("FAIL %s: got %h expected valid BCD at %0t", name, act, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && m_valid) begin
            check("model_t99", out99, to_bcd(m99));
            check("model_t59", out59, to_bcd(m59));
            check_bcd("bcd_t99", out99);
            check_bcd("bcd_t59", out59);
        end
    end

    // ---------------- directed table ----------------
    typedef struct {
        logic       rst;
        logic       en;
        int         edges;
        logic [7:0] exp99;
        logic [7:0] exp59;
    } vec_t;

    vec_t vecs[9];

    task automatic run_edges(input logic r, input logic e, input int n);
        reset = r;
        x     = e;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1,  8'h00, 8'h00};
        vecs[1] = '{1'b1, 1'b1, 1,  8'h00, 8'h00};
        vecs[2] = '{1'b0, 1'b1, 10, 8'h10, 8'h10};
        vecs[3] = '{1'b0, 1'b1, 9,  8'h19, 8'h19};
        vecs[4] = '{1'b0, 1'b1, 1,  8'h20, 8'h20};
        vecs[5] = '{1'b0, 1'b0, 3,  8'h20, 8'h20};
        vecs[6] = '{1'b0, 1'b1, 27, 8'h47, 8'h47};
        vecs[7] = '{1'b1, 1'b1, 1,  8'h00, 8'h00};
        vecs[8] = '{1'b0, 1'b1, 1,  8'h01, 8'h01};

        reset = 1'b0;
        x     = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_edges(vecs[i].rst, vecs[i].en, vecs[i].edges);
            check($sformatf("vec%0d_t99", i), out99, vecs[i].exp99);
            check($sformatf("vec%0d_t59", i), out59, vecs[i].exp59);
        end

        // Terminal handling for both instances, from a fresh reset.
        run_edges(1'b1, 1'b0, 1);
        run_edges(1'b0, 1'b1, 59);
        check("to59_t99", out99, 8'h59);
        check("to59_t59", out59, 8'h59);
        run_edges(1'b0, 1'b1, 1);
        check("edge60_t99", out99, 8'h60);
        check("edge60_t59", out59, SAT ? 8'h59 : 8'h00);
        run_edges(1'b0, 1'b1, 39);
        check("to99_t99", out99, 8'h99);
        check("to99_t59", out59, SAT ? 8'h59 : 8'h39);
        run_edges(1'b0, 1'b1, 1);
        check("wrap_t99", out99, SAT ? 8'h99 : 8'h00);
        check("wrap_t59", out59, SAT ? 8'h59 : 8'h40);
        run_edges(1'b0, 1'b1, 5);
        check("post5_t99", out99, SAT ? 8'h99 : 8'h05);
        check("post5_t59", out59, SAT ? 8'h59 : 8'h45);
        run_edges(1'b0, 1'b0, 3);
        check("hold_t99", out99, SAT ? 8'h99 : 8'h05);
        check("hold_t59", out59, SAT ? 8'h59 : 8'h45);

        // Enable toggling every 15 ns, never coincident with a rising edge.
        run_edges(1'b1, 1'b0, 1);
        reset = 1'b0;
        #2;
        repeat (133) begin
            x = ~x;
            #15;
        end

        // Random enable with occasional reset pulses, driven at falling edges.
        repeat (600) begin
            @(negedge clk);
            x     = 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 79) == 0);
        end
        @(negedge clk);
        reset = 1'b0;
        x     = 1'b0;
        @(negedge clk);
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
